// File: rtl/tausworth_urand.sv
// rtl/tausworth_urand.sv - multi-channel taus88 uniform random source with seeding, warm-up and valid/ready output
//
// Purpose:
//   N_CH independent three-component taus88 combined generators. After reset
//   or a seed load, every channel discards WARMUP steps. It then delivers one
//   32-bit word per channel per accepted transfer, in the format chosen by FMT.
//
// Ports:
//   CLK         clock
//   RESET_N     asynchronous active-low reset
//   seed_valid  one-cycle strobe; reloads all channels from seed, always accepted
//   seed        {s3_seed, s2_seed, s1_seed}
//   out_ready   consumer accepts out_data this cycle
//   out_valid   out_data holds N_CH fresh words
//   out_data    channel k at bits [32k+:32]
//   error       sticky: some component state collapsed to a degenerate value
//   count       accepted transfers, wraps at 2^CNT_W

module tausworth_urand #(
  parameter int          DELAY    = 1,
  parameter int          N_CH     = 4,
  parameter int          FMT      = 1,
  parameter int          WARMUP   = 16,
  parameter int          SEED_FIX = 1,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] DEF_SEED = 32'd12345
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                seed_valid,
  input  logic [95:0]         seed,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [32*N_CH-1:0]  out_data,
  output logic                error,
  output logic [CNT_W-1:0]    count
);

  // Largest value each component must exceed to stay on its full-period orbit.
  localparam logic [31:0] S1_LIM = 32'd1;
  localparam logic [31:0] S2_LIM = 32'd7;
  localparam logic [31:0] S3_LIM = 32'd15;

  // DELAY only shapes behavioural timing in simulation models; the registered
  // outputs here update on the clock edge and the value is only range-checked.
  if (N_CH < 1 || N_CH > 16 || WARMUP < 1 || WARMUP > 255 ||
      FMT < 0 || FMT > 2 || CNT_W < 1 || DELAY < 0) begin : g_param_check
    $error("tausworth_urand: parameter out of range");
  end

  typedef enum logic {
    ST_WARMUP,
    ST_RUN
  } state_t;

  // Per-channel decorrelation: seed_j XOR (k * golden-ratio constant), and
  // optionally lift an illegal small value by setting the MSB.
  function automatic logic [31:0] seed_xform(input logic [31:0] s, input int k,
                                             input logic [31:0] lim);
    logic [31:0] kk;
    logic [31:0] v;
    kk = 32'(k);
    kk = kk * 32'h9E37_79B9;
    v  = s ^ kk;
    if (SEED_FIX != 0 && v <= lim) begin
      v = v | 32'h8000_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] step_s1(input logic [31:0] s);
    return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
  endfunction

  function automatic logic [31:0] step_s2(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
  endfunction

  function automatic logic [31:0] step_s3(input logic [31:0] s);
    return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
  endfunction

  // Float formats keep the 23 low random bits as mantissa under a fixed
  // exponent, giving a uniform float without a divide.
  function automatic logic [31:0] fmt_word(input logic [31:0] r);
    logic [31:0] w;
    case (FMT)
      1:       w = {1'b0, 8'h7F, r[22:0]};
      2:       w = {1'b0, 8'h7E, r[22:0]};
      default: w = r;
    endcase
    return w;
  endfunction

  state_t      state_q, state_d;
  logic [7:0]  warm_q, warm_d;
  logic        step_en;
  logic        load;
  logic        degen;

  logic [31:0] s1_q [N_CH];
  logic [31:0] s2_q [N_CH];
  logic [31:0] s3_q [N_CH];
  logic [31:0] s1_d [N_CH];
  logic [31:0] s2_d [N_CH];
  logic [31:0] s3_d [N_CH];
  logic [31:0] n1   [N_CH];
  logic [31:0] n2   [N_CH];
  logic [31:0] n3   [N_CH];

  logic [32*N_CH-1:0] data_d;

  // FSM next state. seed_valid overrides whatever the state logic decided.
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    step_en = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      ST_WARMUP: begin
        step_en = 1'b1;
        if (warm_q == 8'(WARMUP - 1)) begin
          state_d = ST_RUN;
          warm_d  = '0;
        end else begin
          warm_d = warm_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (!out_valid || out_ready) begin
          load    = 1'b1;
          step_en = 1'b1;
        end
      end
      default: begin
        state_d = ST_WARMUP;
        warm_d  = '0;
      end
    endcase
    if (seed_valid) begin
      state_d = ST_WARMUP;
      warm_d  = '0;
    end
  end

  // Generator datapath: step every channel, pick reload / step / hold.
  always_comb begin
    degen  = 1'b0;
    data_d = '0;
    for (int k = 0; k < N_CH; k++) begin
      n1[k] = step_s1(s1_q[k]);
      n2[k] = step_s2(s2_q[k]);
      n3[k] = step_s3(s3_q[k]);
      data_d[32*k +: 32] = fmt_word(n1[k] ^ n2[k] ^ n3[k]);
      if (step_en && (n1[k][31:1] == '0 || n2[k][31:3] == '0 || n3[k][31:4] == '0)) begin
        degen = 1'b1;
      end
      if (seed_valid) begin
        s1_d[k] = seed_xform(seed[31:0],  k, S1_LIM);
        s2_d[k] = seed_xform(seed[63:32], k, S2_LIM);
        s3_d[k] = seed_xform(seed[95:64], k, S3_LIM);
      end else if (step_en) begin
        s1_d[k] = n1[k];
        s2_d[k] = n2[k];
        s3_d[k] = n3[k];
      end else begin
        s1_d[k] = s1_q[k];
        s2_d[k] = s2_q[k];
        s3_d[k] = s3_q[k];
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_WARMUP;
      warm_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      error     <= 1'b0;
      count     <= '0;
      for (int k = 0; k < N_CH; k++) begin
        s1_q[k] <= seed_xform(DEF_SEED, k, S1_LIM);
        s2_q[k] <= seed_xform(DEF_SEED, k, S2_LIM);
        s3_q[k] <= seed_xform(DEF_SEED, k, S3_LIM);
      end
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      for (int k = 0; k < N_CH; k++) begin
        s1_q[k] <= s1_d[k];
        s2_q[k] <= s2_d[k];
        s3_q[k] <= s3_d[k];
      end

      // A transfer in the seed cycle still counts; the seed only blocks new data.
      if (out_valid && out_ready) begin
        count <= count + CNT_W'(1);
      end

      if (seed_valid) begin
        out_valid <= 1'b0;
        error     <= 1'b0;
      end else begin
        if (load) begin
          out_valid <= 1'b1;
          out_data  <= data_d;
        end
        if (degen) begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule
